coin_acceptor_frontend: RTL

Upstream stage of the vending machine FSM. It takes the raw, asynchronous, bouncy nickel and dime sensor levels from the coin slot and synchronises and debounces them. Each valid coin produces exactly one single-cycle N or D pulse for the vending machine's registered inputs. Invalid events (both sensors active, or acceptance disabled) produce a reject pulse, and a stuck sensor raises a jam flag.

---
 rtl/coin_acceptor_frontend.sv | 119 +++++++++++
 1 files changed

// File: rtl/coin_acceptor_frontend.sv
// coin_acceptor_frontend: synchronises and debounces the coin slot sensors and emits
// one-cycle N/D/reject pulses plus a jam level for the vending machine FSM.
module coin_acceptor_frontend #(
    parameter int DEB_CYCLES = 4,
    parameter int JAM_CYCLES = 1000,
    parameter int JCNT_W     = 10
) (
    input  logic clk,
    input  logic rstn,
    input  logic coin_n_raw,
    input  logic coin_d_raw,
    input  logic accept_en,
    output logic N,
    output logic D,
    output logic reject,
    output logic jam
);
    typedef enum logic [1:0] {IDLE, DEBOUNCE, RELEASE, JAM} state_t;
    localparam logic [7:0]        DEB_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [JCNT_W-1:0] JAM_LAST = JCNT_W'(JAM_CYCLES - 1);

    logic              n_meta_q, d_meta_q;
    logic [1:0]        s_q;
    state_t            state_q, state_d;
    logic [1:0]        cand_q, cand_d;
    logic [7:0]        deb_cnt_q, deb_cnt_d, deb_inc;
    logic [JCNT_W-1:0] jam_cnt_q, jam_cnt_d, jam_inc;
    logic              nick_q, nick_d, dime_q, dime_d, rej_q, rej_d, jam_q, jam_d;

    assign deb_inc = (deb_cnt_q == '1) ? deb_cnt_q : deb_cnt_q + 8'd1;
    assign jam_inc = (jam_cnt_q == '1) ? jam_cnt_q : jam_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        jam_cnt_d = jam_cnt_q;
        nick_d    = 1'b0;
        dime_d    = 1'b0;
        rej_d     = 1'b0;
        jam_d     = jam_q;
        case (state_q)
            IDLE: if (s_q != 2'b00) begin
                state_d   = DEBOUNCE;
                cand_d    = s_q;
                deb_cnt_d = 8'd1;
            end
            DEBOUNCE: if (s_q == 2'b00) begin
                state_d   = IDLE;
                deb_cnt_d = '0;
            end else if (s_q != cand_q) begin
                cand_d    = s_q;
                deb_cnt_d = 8'd1;
            end else if (deb_cnt_q == DEB_LAST) begin
                state_d   = RELEASE;
                deb_cnt_d = '0;
                jam_cnt_d = '0;
                nick_d    = accept_en && cand_q == 2'b10;
                dime_d    = accept_en && cand_q == 2'b01;
                rej_d     = !(accept_en && cand_q != 2'b11);
            end else begin
                deb_cnt_d = deb_inc;
            end
            // RELEASE and JAM share the "chute clear for DEB_CYCLES samples" exit
            RELEASE, JAM: if (s_q == 2'b00) begin
                if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                    jam_cnt_d = '0;
                    jam_d     = 1'b0;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end else if (state_q == RELEASE && jam_cnt_q == JAM_LAST) begin
                state_d   = JAM;
                deb_cnt_d = '0;
                jam_cnt_d = '0;
                jam_d     = 1'b1;
            end else begin
                deb_cnt_d = '0;
                if (state_q == RELEASE) jam_cnt_d = jam_inc;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            n_meta_q  <= 1'b0;
            d_meta_q  <= 1'b0;
            s_q       <= 2'b00;
            state_q   <= IDLE;
            cand_q    <= 2'b00;
            deb_cnt_q <= '0;
            jam_cnt_q <= '0;
            nick_q    <= 1'b0;
            dime_q    <= 1'b0;
            rej_q     <= 1'b0;
            jam_q     <= 1'b0;
        end else begin
            n_meta_q  <= coin_n_raw;
            d_meta_q  <= coin_d_raw;
            s_q       <= {n_meta_q, d_meta_q};
            state_q   <= state_d;
            cand_q    <= cand_d;
            deb_cnt_q <= deb_cnt_d;
            jam_cnt_q <= jam_cnt_d;
            nick_q    <= nick_d;
            dime_q    <= dime_d;
            rej_q     <= rej_d;
            jam_q     <= jam_d;
        end
    end

    assign N      = nick_q;
    assign D      = dime_q;
    assign reject = rej_q;
    assign jam    = jam_q;
endmodule
